// File: rtl/vx_lsu_store_tracker_if.sv
// Handshake bundle between the LSU slices/scheduler (master) and the store tracker (slave).
// Optional perf counter ports appear when LSU_STORE_TRACKER_PERF_EN is defined.
interface vx_lsu_store_tracker_if #(
  parameter int NUM_BLOCKS = 2,
  parameter int NUM_WARPS  = 8
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic [NUM_BLOCKS-1:0]          st_issue_valid;
  logic [NUM_BLOCKS*NW_WIDTH-1:0] st_issue_wid;
  logic [NUM_BLOCKS-1:0]          st_issue_ready;
  logic [NUM_BLOCKS-1:0]          st_ack_valid;
  logic [NUM_BLOCKS*NW_WIDTH-1:0] st_ack_wid;
  logic                           fence_valid;
  logic [NW_WIDTH-1:0]            fence_wid;
  logic                           fence_ready;
  logic [NUM_WARPS-1:0]           warp_pending;
  logic                           no_pending_stores;
  logic                           underflow_err;
`ifdef LSU_STORE_TRACKER_PERF_EN
  logic [31:0]                    perf_fence_stalls;
  logic [31:0]                    perf_issue_stalls;

  modport master (
    output st_issue_valid, st_issue_wid, st_ack_valid, st_ack_wid, fence_valid, fence_wid,
    input  st_issue_ready, fence_ready, warp_pending, no_pending_stores, underflow_err,
           perf_fence_stalls, perf_issue_stalls
  );
  modport slave (
    input  st_issue_valid, st_issue_wid, st_ack_valid, st_ack_wid, fence_valid, fence_wid,
    output st_issue_ready, fence_ready, warp_pending, no_pending_stores, underflow_err,
           perf_fence_stalls, perf_issue_stalls
  );
`else
  modport master (
    output st_issue_valid, st_issue_wid, st_ack_valid, st_ack_wid, fence_valid, fence_wid,
    input  st_issue_ready, fence_ready, warp_pending, no_pending_stores, underflow_err
  );
  modport slave (
    input  st_issue_valid, st_issue_wid, st_ack_valid, st_ack_wid, fence_valid, fence_wid,
    output st_issue_ready, fence_ready, warp_pending, no_pending_stores, underflow_err
  );
`endif
endinterface

// File: rtl/vx_lsu_store_tracker.sv
// Per-(block, warp) outstanding-store counters with per-warp pending status and fence handshake.
// Define LSU_STORE_TRACKER_PERF_EN to add fence/issue stall performance counters.
module vx_lsu_store_tracker #(
  parameter int NUM_BLOCKS = 2,
  parameter int NUM_WARPS  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_lsu_store_tracker_if.slave  bus
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_BLOCKS][NUM_WARPS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_BLOCKS][NUM_WARPS];
  logic                 uf_q, uf_d;
  logic [NUM_BLOCKS-1:0] issue_ready;
  logic [NUM_WARPS-1:0]  warp_pending;
  logic                  fence_pending;

  // Ready looks only at registered counts; a same-cycle ack never frees a full slot.
  always_comb begin
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      issue_ready[b] = 1'b1;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (bus.st_issue_wid[b*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w) && cnt_q[b][w] == CNT_MAX)
          issue_ready[b] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        logic inc, dec;
        inc = bus.st_issue_valid[b] && issue_ready[b] &&
              (bus.st_issue_wid[b*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w));
        dec = bus.st_ack_valid[b] &&
              (bus.st_ack_wid[b*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w));
        if (inc && !dec) begin
          cnt_d[b][w] = cnt_q[b][w] + CNT_ONE;
        end else if (dec && !inc) begin
          if (cnt_q[b][w] == '0) uf_d = 1'b1;
          else                   cnt_d[b][w] = cnt_q[b][w] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BLOCKS; b++)
        for (int w = 0; w < NUM_WARPS; w++)
          cnt_q[b][w] <= '0;
      uf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  always_comb begin
    fence_pending = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_pending[w] = 1'b0;
      for (int b = 0; b < NUM_BLOCKS; b++)
        if (cnt_q[b][w] != '0) warp_pending[w] = 1'b1;
      if (bus.fence_wid == NW_WIDTH'(w) && warp_pending[w]) fence_pending = 1'b1;
    end
  end

  assign bus.st_issue_ready    = issue_ready;
  assign bus.warp_pending      = warp_pending;
  assign bus.no_pending_stores = ~|warp_pending;
  assign bus.underflow_err     = uf_q;
  assign bus.fence_ready       = bus.fence_valid & ~fence_pending;

`ifdef LSU_STORE_TRACKER_PERF_EN
  logic [31:0] perf_fence_q, perf_fence_d;
  logic [31:0] perf_issue_q, perf_issue_d;

  always_comb begin
    perf_fence_d = perf_fence_q;
    perf_issue_d = perf_issue_q;
    if (bus.fence_valid && fence_pending)           perf_fence_d = perf_fence_q + 32'd1;
    if (|(bus.st_issue_valid & ~issue_ready))       perf_issue_d = perf_issue_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fence_q <= '0;
      perf_issue_q <= '0;
    end else begin
      perf_fence_q <= perf_fence_d;
      perf_issue_q <= perf_issue_d;
    end
  end

  assign bus.perf_fence_stalls = perf_fence_q;
  assign bus.perf_issue_stalls = perf_issue_q;
`endif
endmodule
